// File: rtl/simple_bus_pkg.sv
// Shared encodings and helpers for the simple bus responder: access-size
// codes, legal latency bounds, response-slot FSM states, and the byte-enable
// and alignment decoders used on the data port.
package simple_bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } slot_state_e;

    // Lane mask for a store; an illegal size enables no lanes.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // True when the access cannot be served as a naturally aligned unit.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b1;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = (addr_lo != 2'b00);
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/simple_bus_rsp_slot.sv
// One outstanding-read tracker per bus port. The read word and its error flag
// are captured when the read is accepted and presented for exactly one cycle
// LATENCY cycles later. Response fields are forced to zero outside that pulse.
module simple_bus_rsp_slot
    import simple_bus_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_accept_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_err_i,
    output logic        cmd_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o
);

    // Out-of-range LATENCY values are clamped to the supported window.
    localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                             (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [1:0] CNT_LOAD = 2'(LAT_EFF - 1);

    slot_state_e state_q;
    logic [1:0]  cnt_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic [31:0] hold_data_q;
    logic        hold_err_q;

    // Slot FSM with registered outputs; ready is low only while waiting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            hold_data_q <= 32'd0;
            hold_err_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (rd_accept_i) begin
                        if (LAT_EFF == 1) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rd_data_i;
                            rsp_err_q   <= rd_err_i;
                        end else begin
                            state_q     <= S_WAIT;
                            cnt_q       <= CNT_LOAD;
                            cmd_ready_q <= 1'b0;
                            hold_data_q <= rd_data_i;
                            hold_err_q  <= rd_err_i;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 2'd1) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= hold_data_q;
                        rsp_err_q   <= hold_err_q;
                    end else begin
                        cnt_q       <= cnt_q - 2'd1;
                        cmd_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: rtl/simple_bus_responder.sv
// Memory-backed responder for an instruction fetch port and a data port.
// One word array serves two combinational read ports and one byte-lane write
// port. Reads are captured at accept, so a same-edge store to the same word
// is not visible to that read. Memory is intentionally not reset.
module simple_bus_responder
    import simple_bus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iBus_cmd_valid,
    output logic        iBus_cmd_ready,
    input  logic [31:0] iBus_cmd_payload_pc,
    output logic        iBus_rsp_ready,
    output logic [31:0] iBus_rsp_inst,
    output logic        iBus_rsp_error,
    input  logic        dBus_cmd_valid,
    input  logic        dBus_cmd_payload_wr,
    input  logic [31:0] dBus_cmd_payload_address,
    input  logic [31:0] dBus_cmd_payload_data,
    input  logic [1:0]  dBus_cmd_payload_size,
    output logic        dBus_cmd_ready,
    output logic        dBus_rsp_ready,
    output logic [31:0] dBus_rsp_data,
    output logic        dBus_rsp_error
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0] mem_q [MEM_WORDS];

    logic [29:0]   i_widx;
    logic [AW-1:0] i_idx;
    logic          i_in_range;
    logic          i_accept;
    logic [31:0]   i_rd_data;
    logic          i_rd_err;
    logic          unused_pc_bits;

    logic [29:0]   d_widx;
    logic [AW-1:0] d_idx;
    logic          d_in_range;
    logic          d_mis;
    logic [3:0]    d_be;
    logic          d_accept;
    logic          d_rd_accept;
    logic          d_store_we;
    logic [31:0]   d_rd_data;
    logic          d_rd_err;

    // Fetches are word reads; the low pc bits select nothing.
    assign i_widx         = iBus_cmd_payload_pc[31:2];
    assign i_idx          = i_widx[AW-1:0];
    assign i_in_range     = ({2'b00, i_widx} < 32'(MEM_WORDS));
    assign i_accept       = iBus_cmd_valid && iBus_cmd_ready;
    assign i_rd_err       = !i_in_range;
    assign i_rd_data      = i_in_range ? mem_q[i_idx] : 32'd0;
    assign unused_pc_bits = ^iBus_cmd_payload_pc[1:0];

    assign d_widx      = dBus_cmd_payload_address[31:2];
    assign d_idx       = d_widx[AW-1:0];
    assign d_in_range  = ({2'b00, d_widx} < 32'(MEM_WORDS));
    assign d_mis       = is_misaligned(dBus_cmd_payload_size, dBus_cmd_payload_address[1:0]);
    assign d_be        = byte_enables(dBus_cmd_payload_size, dBus_cmd_payload_address[1:0]);
    assign d_accept    = dBus_cmd_valid && dBus_cmd_ready;
    assign d_rd_accept = d_accept && !dBus_cmd_payload_wr;
    assign d_store_we  = d_accept && dBus_cmd_payload_wr && d_in_range && !d_mis;
    assign d_rd_err    = d_mis || !d_in_range;
    assign d_rd_data   = d_rd_err ? 32'd0 : mem_q[d_idx];

    // Byte-lane store; faulting stores never reach the array.
    always_ff @(posedge clock) begin
        if (d_store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be[b]) begin
                    mem_q[d_idx][8*b +: 8] <= dBus_cmd_payload_data[8*b +: 8];
                end
            end
        end
    end

    simple_bus_rsp_slot #(
        .LATENCY(LATENCY)
    ) u_islot (
        .clk_i       (clock),
        .rst_i       (reset),
        .rd_accept_i (i_accept),
        .rd_data_i   (i_rd_data),
        .rd_err_i    (i_rd_err),
        .cmd_ready_o (iBus_cmd_ready),
        .rsp_valid_o (iBus_rsp_ready),
        .rsp_data_o  (iBus_rsp_inst),
        .rsp_err_o   (iBus_rsp_error)
    );

    simple_bus_rsp_slot #(
        .LATENCY(LATENCY)
    ) u_dslot (
        .clk_i       (clock),
        .rst_i       (reset),
        .rd_accept_i (d_rd_accept),
        .rd_data_i   (d_rd_data),
        .rd_err_i    (d_rd_err),
        .cmd_ready_o (dBus_cmd_ready),
        .rsp_valid_o (dBus_rsp_ready),
        .rsp_data_o  (dBus_rsp_data),
        .rsp_err_o   (dBus_rsp_error)
    );

endmodule

// File: tb/tb_simple_bus_responder.sv
// Bench for simple_bus_responder: three instances with LATENCY 1, 2 and 3
// share payload buses, each with its own valid strobes and reset.
module tb_simple_bus_responder;
    import simple_bus_pkg::*;

    localparam int MW = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst;
    logic [2:0]        ib_v;
    logic [31:0]       pc;
    logic [2:0]        ib_cr, ib_rr, ib_err;
    logic [2:0][31:0]  ib_inst;
    logic [2:0]        db_v;
    logic              wr;
    logic [31:0]       addr, wdata;
    logic [1:0]        size;
    logic [2:0]        db_cr, db_rr, db_err;
    logic [2:0][31:0]  db_data;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        simple_bus_responder #(
            .MEM_WORDS(MW),
            .LATENCY  (g + 1)
        ) u_dut (
            .clock                    (clk),
            .reset                    (rst[g]),
            .iBus_cmd_valid           (ib_v[g]),
            .iBus_cmd_ready           (ib_cr[g]),
            .iBus_cmd_payload_pc      (pc),
            .iBus_rsp_ready           (ib_rr[g]),
            .iBus_rsp_inst            (ib_inst[g]),
            .iBus_rsp_error           (ib_err[g]),
            .dBus_cmd_valid           (db_v[g]),
            .dBus_cmd_payload_wr      (wr),
            .dBus_cmd_payload_address (addr),
            .dBus_cmd_payload_data    (wdata),
            .dBus_cmd_payload_size    (size),
            .dBus_cmd_ready           (db_cr[g]),
            .dBus_rsp_ready           (db_rr[g]),
            .dBus_rsp_data            (db_data[g]),
            .dBus_rsp_error           (db_err[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Issue one dBus command on instance k; returns #1 after the accept edge.
    task automatic dbus_op(input int k, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s);
        chk("db_ready_before_cmd", {31'd0, db_cr[k]}, 32'd1);
        wr = w; addr = a; wdata = d; size = s; db_v[k] = 1'b1;
        @(posedge clk); #1;
        db_v[k] = 1'b0;
    endtask

    // LATENCY=1 fetch on instance 0: response is visible right after accept.
    task automatic fetch1(input string nm, input logic [31:0] a,
                          input logic [31:0] e_inst, input logic e_err);
        chk({nm, "_cr"}, {31'd0, ib_cr[0]}, 32'd1);
        pc = a; ib_v[0] = 1'b1;
        @(posedge clk); #1;
        ib_v[0] = 1'b0;
        chk({nm, "_rr"},   {31'd0, ib_rr[0]}, 32'd1);
        chk({nm, "_inst"}, ib_inst[0], e_inst);
        chk({nm, "_err"},  {31'd0, ib_err[0]}, {31'd0, e_err});
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        logic        e_err;
        logic [31:0] e_data;
        string       nm;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic quiet;
        rst = 3'b111; ib_v = '0; db_v = '0; pc = '0;
        wr = 1'b0; addr = '0; wdata = '0; size = SIZE_WORD;

        tbl[0]  = '{1'b1, 32'h0000_0040, 32'h0000_0013, SIZE_WORD, 1'b0, 32'h0, "st_w40"};
        tbl[1]  = '{1'b1, 32'h0000_0100, 32'h1122_3344, SIZE_WORD, 1'b0, 32'h0, "st_w100"};
        tbl[2]  = '{1'b1, 32'h0000_0101, 32'h0000_AB00, SIZE_BYTE, 1'b0, 32'h0, "st_b101"};
        tbl[3]  = '{1'b0, 32'h0000_0100, 32'h0,         SIZE_WORD, 1'b0, 32'h1122_AB44, "ld_after_byte"};
        tbl[4]  = '{1'b1, 32'h0000_0103, 32'hFFFF_0000, SIZE_HALF, 1'b0, 32'h0, "st_h103_mis"};
        tbl[5]  = '{1'b0, 32'h0000_0100, 32'h0,         SIZE_WORD, 1'b0, 32'h1122_AB44, "ld_after_mis_st"};
        tbl[6]  = '{1'b0, 32'h0000_0102, 32'h0,         SIZE_WORD, 1'b1, 32'h0, "ld_w102_mis"};
        tbl[7]  = '{1'b1, 32'h0000_0102, 32'h5566_0000, SIZE_HALF, 1'b0, 32'h0, "st_h102"};
        tbl[8]  = '{1'b0, 32'h0000_0102, 32'h0,         SIZE_HALF, 1'b0, 32'h5566_AB44, "ld_h102"};
        tbl[9]  = '{1'b0, 32'h0000_0100, 32'h0,         2'd3,      1'b1, 32'h0, "ld_size3"};
        tbl[10] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, SIZE_WORD, 1'b0, 32'h0, "st_w0"};
        tbl[11] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, SIZE_WORD, 1'b0, 32'h0, "st_oor"};
        tbl[12] = '{1'b0, 32'h0000_0000, 32'h0,         SIZE_WORD, 1'b0, 32'hCAFE_F00D, "ld_w0_after_oor"};
        tbl[13] = '{1'b0, 32'h0000_1000, 32'h0,         SIZE_WORD, 1'b1, 32'h0, "ld_oor"};
        tbl[14] = '{1'b0, 32'h0000_0103, 32'h0,         SIZE_BYTE, 1'b0, 32'h5566_AB44, "ld_b103"};
        tbl[15] = '{1'b0, 32'h0000_0101, 32'h0,         SIZE_HALF, 1'b1, 32'h0, "ld_h101_mis"};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ib_cr",   {31'd0, ib_cr[0]}, 32'd0);
        chk("rst_db_cr",   {31'd0, db_cr[0]}, 32'd0);
        chk("rst_ib_rr",   {31'd0, ib_rr[0]}, 32'd0);
        chk("rst_db_data", db_data[0], 32'd0);
        chk("rst_db_err",  {31'd0, db_err[0]}, 32'd0);
        rst = 3'b000;
        #1;
        chk("rel_cr_before_edge", {31'd0, ib_cr[0]}, 32'd0);
        @(posedge clk); #1;
        chk("rel_ib_cr_edge1", {31'd0, ib_cr[0]}, 32'd1);
        chk("rel_db_cr_edge1", {31'd0, db_cr[0]}, 32'd1);
        chk("rel_l3_cr_edge1", {31'd0, ib_cr[2]}, 32'd1);

        // Table: dBus stores and loads on the LATENCY=1 instance
        for (int i = 0; i < 16; i++) begin
            dbus_op(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s);
            if (tbl[i].wr) begin
                chk({tbl[i].nm, "_norsp"}, {31'd0, db_rr[0]}, 32'd0);
            end else begin
                chk({tbl[i].nm, "_rr"},   {31'd0, db_rr[0]}, 32'd1);
                chk({tbl[i].nm, "_data"}, db_data[0], tbl[i].e_data);
                chk({tbl[i].nm, "_err"},  {31'd0, db_err[0]}, {31'd0, tbl[i].e_err});
            end
        end
        @(posedge clk); #1;
        chk("db_rsp_gap_rr",   {31'd0, db_rr[0]}, 32'd0);
        chk("db_rsp_gap_data", db_data[0], 32'd0);

        // iBus fetches on LATENCY=1
        fetch1("f_40", 32'h0000_0040, 32'h0000_0013, 1'b0);
        @(posedge clk); #1;
        chk("f_gap_rr",   {31'd0, ib_rr[0]}, 32'd0);
        chk("f_gap_inst", ib_inst[0], 32'd0);
        fetch1("f_oor", 32'h0000_1000, 32'h0, 1'b1);

        // Back-to-back fetches, one per cycle
        pc = 32'h0000_0040; ib_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("b2b_1_inst", ib_inst[0], 32'h0000_0013);
        chk("b2b_1_cr",   {31'd0, ib_cr[0]}, 32'd1);
        pc = 32'h0000_0100;
        @(posedge clk); #1;
        ib_v[0] = 1'b0;
        chk("b2b_2_rr",   {31'd0, ib_rr[0]}, 32'd1);
        chk("b2b_2_inst", ib_inst[0], 32'h5566_AB44);

        // Same-edge fetch and store to one word return the old value
        dbus_op(0, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, SIZE_WORD);
        pc = 32'h0000_0104; ib_v[0] = 1'b1;
        wr = 1'b1; addr = 32'h0000_0104; wdata = 32'h600D_CAFE; size = SIZE_WORD; db_v[0] = 1'b1;
        @(posedge clk); #1;
        ib_v[0] = 1'b0; db_v[0] = 1'b0;
        chk("same_edge_old", ib_inst[0], 32'h0BAD_F00D);
        fetch1("same_edge_new", 32'h0000_0104, 32'h600D_CAFE, 1'b0);

        // LATENCY=3 back-to-back fetches
        dbus_op(2, 1'b1, 32'h0000_0040, 32'h0000_0013, SIZE_WORD);
        dbus_op(2, 1'b1, 32'h0000_0044, 32'h0000_0077, SIZE_WORD);
        pc = 32'h0000_0040; ib_v[2] = 1'b1;
        @(posedge clk); #1;
        pc = 32'h0000_0044;
        chk("l3_a_c1_cr", {31'd0, ib_cr[2]}, 32'd0);
        chk("l3_a_c1_rr", {31'd0, ib_rr[2]}, 32'd0);
        @(posedge clk); #1;
        chk("l3_a_c2_cr", {31'd0, ib_cr[2]}, 32'd0);
        chk("l3_a_c2_rr", {31'd0, ib_rr[2]}, 32'd0);
        @(posedge clk); #1;
        chk("l3_a_c3_rr",   {31'd0, ib_rr[2]}, 32'd1);
        chk("l3_a_c3_inst", ib_inst[2], 32'h0000_0013);
        chk("l3_a_c3_cr",   {31'd0, ib_cr[2]}, 32'd1);
        @(posedge clk); #1;
        ib_v[2] = 1'b0;
        chk("l3_b_c1_cr",   {31'd0, ib_cr[2]}, 32'd0);
        chk("l3_b_c1_rr",   {31'd0, ib_rr[2]}, 32'd0);
        chk("l3_b_c1_inst", ib_inst[2], 32'd0);
        @(posedge clk); #1;
        chk("l3_b_c2_cr", {31'd0, ib_cr[2]}, 32'd0);
        @(posedge clk); #1;
        chk("l3_b_c3_rr",   {31'd0, ib_rr[2]}, 32'd1);
        chk("l3_b_c3_inst", ib_inst[2], 32'h0000_0077);
        @(posedge clk); #1;
        chk("l3_end_rr", {31'd0, ib_rr[2]}, 32'd0);
        chk("l3_end_cr", {31'd0, ib_cr[2]}, 32'd1);

        // LATENCY=2 load, then reset during a pending load
        dbus_op(1, 1'b1, 32'h0000_0200, 32'h1234_5678, SIZE_WORD);
        dbus_op(1, 1'b0, 32'h0000_0200, 32'h0, SIZE_WORD);
        chk("l2_c1_rr", {31'd0, db_rr[1]}, 32'd0);
        chk("l2_c1_cr", {31'd0, db_cr[1]}, 32'd0);
        @(posedge clk); #1;
        chk("l2_c2_rr",   {31'd0, db_rr[1]}, 32'd1);
        chk("l2_c2_data", db_data[1], 32'h1234_5678);
        @(posedge clk); #1;
        dbus_op(1, 1'b0, 32'h0000_0200, 32'h0, SIZE_WORD);
        rst[1] = 1'b1;
        #1;
        chk("l2_rst_cr", {31'd0, db_cr[1]}, 32'd0);
        chk("l2_rst_rr", {31'd0, db_rr[1]}, 32'd0);
        @(posedge clk); #1;
        chk("l2_rst_hold_rr", {31'd0, db_rr[1]}, 32'd0);
        rst[1] = 1'b0;
        #1;
        chk("l2_rel_cr_pre", {31'd0, db_cr[1]}, 32'd0);
        @(posedge clk); #1;
        chk("l2_rel_cr_edge1", {31'd0, db_cr[1]}, 32'd1);
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (db_rr[1] !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        chk("l2_no_stale_rsp", {31'd0, quiet}, 32'd1);
        dbus_op(1, 1'b0, 32'h0000_0200, 32'h0, SIZE_WORD);
        @(posedge clk); #1;
        chk("l2_mem_kept_rr",   {31'd0, db_rr[1]}, 32'd1);
        chk("l2_mem_kept_data", db_data[1], 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
